seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: scan states and segment patterns.
// Latency: none (constants only). Backpressure: none.
// Patterns are {g,f,e,d,c,b,a} with active-low segments.
package seg7_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry n is the pattern for hex digit n; the list is written from F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low seven-segment pattern.
// Latency: combinational. Backpressure: none.
// Shared with the register-wrapper readback path.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scans DIGITS seven-segment digits with blanking, PWM dimming and frame-aligned double buffering.
// Latency: outputs registered one cycle after scan state. Backpressure: none, load_i is always accepted.
// A load lands in the shadow set and is promoted to the active set on the last cycle of a frame.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int CLK_DIV   = 1000,
    parameter int BLANK_CYC = 16,
    parameter int BRIGHT_W  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   num_i,
    input  logic [DIGITS-1:0]     en_mask_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [BRIGHT_W-1:0]   bright_i,
    input  logic                  load_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            cath_o,
    output logic                  dp_o,
    output logic                  frame_o,
    output logic                  pending_o
);

    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SLOT_W = $clog2(CLK_DIV);

    localparam logic [DIG_W-1:0]  LAST_DIG   = DIG_W'(DIGITS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] LAST_BLANK = SLOT_W'(BLANK_CYC - 1);

    localparam logic [0:0] ST_BLANK = BLANK;
    localparam logic [0:0] ST_DRIVE = DRIVE;

    logic [0:0]          state;
    logic [DIG_W-1:0]    digit;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [BRIGHT_W-1:0] pwm_cnt;

    logic [4*DIGITS-1:0] sh_num;
    logic [DIGITS-1:0]   sh_mask;
    logic [DIGITS-1:0]   sh_dp;
    logic [BRIGHT_W-1:0] sh_bright;
    logic                pending;

    logic [4*DIGITS-1:0] act_num;
    logic [DIGITS-1:0]   act_mask;
    logic [DIGITS-1:0]   act_dp;
    logic [BRIGHT_W-1:0] act_bright;

    logic       slot_end;
    logic       frame_end;
    logic       light;
    logic       lit;
    logic [3:0] nib;
    logic [6:0] seg;

    assign slot_end  = (slot_cnt == LAST_SLOT);
    assign frame_end = slot_end && (digit == LAST_DIG);

    // Zero and full scale bypass the comparator so they mean truly off and truly on.
    always_comb begin
        light = 1'b0;
        if (act_bright == '0)
            light = 1'b0;
        else if (&act_bright)
            light = 1'b1;
        else
            light = (pwm_cnt < act_bright);
    end

    assign lit = (state == ST_DRIVE) && act_mask[digit] && light;
    assign nib = act_num[{digit, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nib (nib),
        .seg (seg)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_BLANK;
            digit    <= '0;
            slot_cnt <= '0;
            pwm_cnt  <= '0;
        end else begin
            if (slot_end) begin
                slot_cnt <= '0;
                digit    <= (digit == LAST_DIG) ? '0 : digit + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            case (state)
                ST_BLANK: begin
                    pwm_cnt <= '0;
                    if (slot_cnt == LAST_BLANK)
                        state <= ST_DRIVE;
                end
                default: begin
                    pwm_cnt <= pwm_cnt + 1'b1;
                    if (slot_end)
                        state <= ST_BLANK;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_num     <= '0;
            sh_mask    <= '0;
            sh_dp      <= '0;
            sh_bright  <= '0;
            pending    <= 1'b0;
            act_num    <= '0;
            act_mask   <= '0;
            act_dp     <= '0;
            act_bright <= '0;
        end else begin
            if (load_i) begin
                sh_num    <= num_i;
                sh_mask   <= en_mask_i;
                sh_dp     <= dp_i;
                sh_bright <= bright_i;
            end

            // A load coinciding with the boundary bypasses the shadow and never raises pending.
            if (frame_end && (pending || load_i)) begin
                act_num    <= load_i ? num_i     : sh_num;
                act_mask   <= load_i ? en_mask_i : sh_mask;
                act_dp     <= load_i ? dp_i      : sh_dp;
                act_bright <= load_i ? bright_i  : sh_bright;
                pending    <= 1'b0;
            end else if (load_i) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            an_o    <= '1;
            cath_o  <= SEG_OFF;
            dp_o    <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            an_o    <= lit ? ~(DIGITS'(1) << digit) : '1;
            cath_o  <= lit ? seg : SEG_OFF;
            dp_o    <= lit ? ~act_dp[digit] : 1'b1;
            frame_o <= frame_end;
        end
    end

    assign pending_o = pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=8, CLK_DIV=64, BLANK_CYC=4, BRIGHT_W=4.
// cyc counts edges since reset release; outputs at cyc c reflect scan position c-1.
module tb_seg7_scan_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] num_i;
    logic [7:0]  en_mask_i;
    logic [7:0]  dp_i;
    logic [3:0]  bright_i;
    logic        load_i;
    logic [7:0]  an_o;
    logic [6:0]  cath_o;
    logic        dp_o;
    logic        frame_o;
    logic        pending_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int k, d, s, r0;
    logic       lit;
    logic [7:0] ea;
    logic [6:0] ec;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_ctrl #(
        .DIGITS    (8),
        .CLK_DIV   (64),
        .BLANK_CYC (4),
        .BRIGHT_W  (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .num_i     (num_i),
        .en_mask_i (en_mask_i),
        .dp_i      (dp_i),
        .bright_i  (bright_i),
        .load_i    (load_i),
        .an_o      (an_o),
        .cath_o    (cath_o),
        .dp_o      (dp_o),
        .frame_o   (frame_o),
        .pending_o (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_load(input logic [31:0] n, input logic [7:0] m, input logic [7:0] p,
                           input logic [3:0] b);
        num_i     = n;
        en_mask_i = m;
        dp_i      = p;
        bright_i  = b;
        load_i    = 1'b1;
        tick();
        load_i    = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] an, input logic [6:0] ca,
                           input logic dp);
        chk({tag, "_an"}, an_o, an);
        chk({tag, "_cath"}, cath_o, ca);
        chk({tag, "_dp"}, dp_o, dp);
    endtask

    initial begin
        rst_i     = 1'b1;
        num_i     = '0;
        en_mask_i = '0;
        dp_i      = '0;
        bright_i  = '0;
        load_i    = 1'b0;
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        chk_out("rst", 8'hFF, 7'h7F, 1'b1);
        chk("rst_frame", frame_o, 1'b0);
        chk("rst_pend", pending_o, 1'b0);
        rst_i = 1'b0;
        cyc   = 0;

        // No load for two frames: dark, frame pulse every 512 cycles.
        for (int c = 1; c <= 1024; c++) begin
            run_to(c);
            chk_out("idle", 8'hFF, 7'h7F, 1'b1);
            chk("idle_frame", frame_o, (c % 512) == 0);
        end

        // Mid-frame load, shown from the next frame.
        run_to(1030);
        do_load(32'h76543210, 8'hFF, 8'h01, 4'hF);
        chk("ld_pend", pending_o, 1'b1);
        run_to(1535);
        chk("ld_pend_hold", pending_o, 1'b1);
        chk_out("ld_old_dark", 8'hFF, 7'h7F, 1'b1);
        run_to(1536);
        chk("ld_frame", frame_o, 1'b1);
        chk("ld_pend_clr", pending_o, 1'b0);
        for (int c = 1537; c <= 1600; c++) begin
            run_to(c);
            if (c >= 1541) chk_out("dig0", 8'hFE, 7'h40, 1'b0);
            else           chk_out("dig0_blank", 8'hFF, 7'h7F, 1'b1);
            chk("dig0_frame", frame_o, 1'b0);
        end
        for (int c = 1729; c <= 1792; c++) begin
            run_to(c);
            if (c >= 1733) chk_out("dig3", 8'hF7, 7'h30, 1'b1);
            else           chk_out("dig3_blank", 8'hFF, 7'h7F, 1'b1);
        end

        // Brightness 4: lit on PWM counts 0..3 of each 16.
        run_to(1800);
        do_load(32'h76543210, 8'hFF, 8'h01, 4'h4);
        for (int c = 2049; c <= 2112; c++) begin
            run_to(c);
            lit = (c >= 2053) && (((c - 2053) % 16) < 4);
            if (lit) chk_out("pwm4_on", 8'hFE, 7'h40, 1'b0);
            else     chk_out("pwm4_off", 8'hFF, 7'h7F, 1'b1);
        end

        // Brightness 0: dark for the whole frame.
        run_to(2200);
        do_load(32'h76543210, 8'hFF, 8'h01, 4'h0);
        for (int c = 2561; c <= 3072; c++) begin
            run_to(c);
            chk("bri0_an", an_o, 8'hFF);
        end

        // Mask 0F: upper four digits stay dark, frame period unchanged.
        run_to(3100);
        do_load(32'h76543210, 8'h0F, 8'h01, 4'hF);
        run_to(3584);
        chk("mask_frame0", frame_o, 1'b1);
        for (int c = 3585; c <= 4096; c++) begin
            run_to(c);
            k   = c - 1 - 3584;
            d   = k / 64;
            s   = k % 64;
            lit = (s >= 4) && (d < 4);
            ea  = lit ? ~(8'd1 << d) : 8'hFF;
            ec  = lit ? hex_tab[d] : 7'h7F;
            chk("mask_an", an_o, ea);
            chk("mask_cath", cath_o, ec);
            chk("mask_dp", dp_o, lit ? (d != 0) : 1'b1);
            chk("mask_frame", frame_o, c == 4096);
        end

        // Two mid-frame loads: the later one wins, display unchanged until the boundary.
        run_to(4200);
        do_load(32'h88888888, 8'hFF, 8'h00, 4'hF);
        chk("ov_pend", pending_o, 1'b1);
        run_to(4250);
        do_load(32'hFFFFFFFF, 8'hFF, 8'h00, 4'hF);
        run_to(4300);
        chk_out("ov_old", 8'hF7, 7'h30, 1'b1);
        chk("ov_pend_hold", pending_o, 1'b1);
        run_to(4608);
        chk("ov_frame", frame_o, 1'b1);
        chk("ov_pend_clr", pending_o, 1'b0);
        run_to(4612);
        chk_out("ov_blank", 8'hFF, 7'h7F, 1'b1);
        run_to(4613);
        chk_out("ov_dig0", 8'hFE, 7'h0E, 1'b1);
        run_to(4933);
        chk_out("ov_dig5", 8'hDF, 7'h0E, 1'b1);

        // Load exactly in the boundary cycle.
        run_to(5119);
        chk("bnd_pend_pre", pending_o, 1'b0);
        do_load(32'hAAAAAAAA, 8'hFF, 8'hFF, 4'hF);
        chk("bnd_frame", frame_o, 1'b1);
        chk("bnd_pend", pending_o, 1'b0);
        run_to(5121);
        chk("bnd_pend2", pending_o, 1'b0);
        run_to(5124);
        chk_out("bnd_blank", 8'hFF, 7'h7F, 1'b1);
        run_to(5125);
        chk_out("bnd_dig0", 8'hFE, 7'h08, 1'b0);

        // Reset during digit-5 drive with a load pending.
        run_to(5450);
        do_load(32'h76543210, 8'hFF, 8'h01, 4'hF);
        chk("pre_rst_pend", pending_o, 1'b1);
        run_to(5455);
        chk_out("pre_rst_dig5", 8'hDF, 7'h08, 1'b0);
        run_to(5460);
        rst_i = 1'b1;
        tick();
        chk_out("mid_rst", 8'hFF, 7'h7F, 1'b1);
        chk("mid_rst_frame", frame_o, 1'b0);
        chk("mid_rst_pend", pending_o, 1'b0);
        rst_i = 1'b0;
        r0    = cyc;
        for (int c = r0 + 1; c <= r0 + 9; c++) begin
            run_to(c);
            chk_out("post_rst_dark", 8'hFF, 7'h7F, 1'b1);
            chk("post_rst_pend", pending_o, 1'b0);
        end
        run_to(r0 + 10);
        do_load(32'h76543210, 8'hFF, 8'h01, 4'hF);
        chk("post_rst_ld_pend", pending_o, 1'b1);
        for (int c = r0 + 12; c <= r0 + 511; c++) begin
            run_to(c);
            chk("post_rst_an", an_o, 8'hFF);
            chk("post_rst_frame", frame_o, 1'b0);
        end
        run_to(r0 + 512);
        chk("post_rst_frame1", frame_o, 1'b1);
        chk("post_rst_pend_clr", pending_o, 1'b0);
        for (int c = r0 + 513; c <= r0 + 517; c++) begin
            run_to(c);
            if (c == r0 + 517) chk_out("post_rst_dig0", 8'hFE, 7'h40, 1'b0);
            else               chk_out("post_rst_blank", 8'hFF, 7'h7F, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
